// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and constants for the multi-cycle control FSM
// Contents: state_e (FSM states), alu_op_e (ALU operation codes),
//           RV32I opcode constants, f3_to_alu() funct3 -> ALU op mapping.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      TRAP
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   // alt selects the funct7[5] variant (SUB for 000, SRA for 101).
   function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_decoder.sv
// rtl/rv_multicycle_ctrl_decoder.sv - combinational RV32I OP/OP-IMM decoder
// Ports:
//   ir_i       in  32  instruction register contents
//   legal_o    out 1   instruction is a supported OP/OP-IMM encoding
//   alu_op_o   out 4   ALU operation
//   op_b_sel_o out 1   0 = rs2 data, 1 = immediate
//   imm_o      out 32  sign-extended I-immediate IR[31:20]
module rv_instr_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output logic        legal_o,
   output alu_op_e     alu_op_o,
   output logic        op_b_sel_o,
   output logic [31:0] imm_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode = ir_i[6:0];
   assign funct3 = ir_i[14:12];
   assign funct7 = ir_i[31:25];

   // Register indices are taken straight from IR by the top level.
   assign unused_fields = ^{ir_i[19:15], ir_i[11:7]};

   always_comb begin
      legal_o    = 1'b0;
      alu_op_o   = ALU_ADD;
      op_b_sel_o = 1'b0;
      imm_o      = {{20{ir_i[31]}}, ir_i[31:20]};
      case (opcode)
         OPC_OP: begin
            alu_op_o = f3_to_alu(funct3, funct7[5]);
            legal_o  = (funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_OPIMM: begin
            op_b_sel_o = 1'b1;
            // Only shifts reinterpret IR[30]; ADDI with a negative immediate stays ADD.
            alu_op_o   = f3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
            case (funct3)
               3'b001:  legal_o = (funct7 == 7'b0000000);
               3'b101:  legal_o = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               default: legal_o = 1'b1;
            endcase
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multi-cycle control FSM for the R/I-type datapath
// Optional feature macro: RV_CTRL_PERF_EN (adds cycle_cnt_o / instret_cnt_o).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, halt_req_i           leave IDLE / return to IDLE after WRITEBACK
//   imem_req_o, imem_ready_i,
//   instr_i, ir_load_o            instruction fetch handshake and IR capture strobe
//   r_addr1_o, r_addr2_o,
//   wr_addr_o                     rs1 / rs2 / rd from IR
//   alu_sel_o, op_b_sel_o, imm_o  registered decode results
//   rf_wr_en_o, pc_en_o           WRITEBACK strobes
//   busy_o, illegal_o, timeout_o  status, sticky trap causes
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_OP_W      = 4,
   parameter int FETCH_TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                halt_req_i,
   output logic                imem_req_o,
   input  logic                imem_ready_i,
   input  logic [31:0]         instr_i,
   output logic                ir_load_o,
   output logic [4:0]          r_addr1_o,
   output logic [4:0]          r_addr2_o,
   output logic [4:0]          wr_addr_o,
   output logic [ALU_OP_W-1:0] alu_sel_o,
   output logic                op_b_sel_o,
   output logic [31:0]         imm_o,
   output logic                rf_wr_en_o,
   output logic                pc_en_o,
   output logic                busy_o,
   output logic                illegal_o,
   output logic                timeout_o
`ifdef RV_CTRL_PERF_EN
  ,output logic [31:0]         cycle_cnt_o,
   output logic [31:0]         instret_cnt_o
`endif
);

   localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
   // Wait count at the start of the last permitted ready=0 cycle.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [31:0]         ir_q, ir_d;
   logic [ALU_OP_W-1:0] alu_sel_q, alu_sel_d;
   logic                op_b_sel_q, op_b_sel_d;
   logic [31:0]         imm_q, imm_d;
   logic                illegal_q, illegal_d;
   logic                timeout_q, timeout_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

   logic                dec_legal;
   alu_op_e             dec_alu_op;
   logic                dec_op_b_sel;
   logic [31:0]         dec_imm;

   rv_instr_decoder u_decoder (
      .ir_i       (ir_q),
      .legal_o    (dec_legal),
      .alu_op_o   (dec_alu_op),
      .op_b_sel_o (dec_op_b_sel),
      .imm_o      (dec_imm)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ir_q       <= '0;
         alu_sel_q  <= ALU_OP_W'(ALU_ADD);
         op_b_sel_q <= 1'b0;
         imm_q      <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         alu_sel_q  <= alu_sel_d;
         op_b_sel_q <= op_b_sel_d;
         imm_q      <= imm_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      alu_sel_d  = alu_sel_q;
      op_b_sel_d = op_b_sel_q;
      imm_d      = imm_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      wait_cnt_d = wait_cnt_q;
      imem_req_o = 1'b0;
      ir_load_o  = 1'b0;
      rf_wr_en_o = 1'b0;
      pc_en_o    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = FETCH;
         end
         FETCH: begin
            imem_req_o = 1'b1;
            // A ready on the final wait cycle still counts as a fetch.
            if (imem_ready_i) begin
               ir_load_o  = 1'b1;
               ir_d       = instr_i;
               wait_cnt_d = '0;
               state_d    = DECODE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d  = 1'b1;
               wait_cnt_d = '0;
               state_d    = TRAP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         DECODE: begin
            alu_sel_d  = ALU_OP_W'(dec_alu_op);
            op_b_sel_d = dec_op_b_sel;
            imm_d      = dec_imm;
            if (dec_legal) begin
               state_d = EXECUTE;
            end else begin
               illegal_d = 1'b1;
               state_d   = TRAP;
            end
         end
         EXECUTE: state_d = WRITEBACK;
         WRITEBACK: begin
            rf_wr_en_o = (ir_q[11:7] != 5'd0);
            pc_en_o    = 1'b1;
            state_d    = halt_req_i ? IDLE : FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   assign r_addr1_o  = ir_q[19:15];
   assign r_addr2_o  = ir_q[24:20];
   assign wr_addr_o  = ir_q[11:7];
   assign alu_sel_o  = alu_sel_q;
   assign op_b_sel_o = op_b_sel_q;
   assign imm_o      = imm_q;
   assign busy_o     = (state_q != IDLE) && (state_q != TRAP);
   assign illegal_o  = illegal_q;
   assign timeout_o  = timeout_q;

`ifdef RV_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q, instret_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (busy_o)               cycle_cnt_q   <= cycle_cnt_q + 32'd1;
         if (state_q == WRITEBACK) instret_cnt_q <= instret_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt_o   = cycle_cnt_q;
   assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - self-checking bench for rv_multicycle_ctrl
// Drives directed and random OP/OP-IMM instruction streams, checks every
// phase of each instruction against expectations derived from the ISA rules.
module tb_rv_multicycle_ctrl;

   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        halt_req_i = 1'b0;
   logic        imem_ready_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic        imem_req_o, ir_load_o, op_b_sel_o, rf_wr_en_o, pc_en_o;
   logic        busy_o, illegal_o, timeout_o;
   logic [4:0]  r_addr1_o, r_addr2_o, wr_addr_o;
   logic [3:0]  alu_sel_o;
   logic [31:0] imm_o;
`ifdef RV_CTRL_PERF_EN
   logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   rv_multicycle_ctrl #(.ALU_OP_W(4), .FETCH_TIMEOUT(TO)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .halt_req_i   (halt_req_i),
      .imem_req_o   (imem_req_o),
      .imem_ready_i (imem_ready_i),
      .instr_i      (instr_i),
      .ir_load_o    (ir_load_o),
      .r_addr1_o    (r_addr1_o),
      .r_addr2_o    (r_addr2_o),
      .wr_addr_o    (wr_addr_o),
      .alu_sel_o    (alu_sel_o),
      .op_b_sel_o   (op_b_sel_o),
      .imm_o        (imm_o),
      .rf_wr_en_o   (rf_wr_en_o),
      .pc_en_o      (pc_en_o),
      .busy_o       (busy_o),
      .illegal_o    (illegal_o),
      .timeout_o    (timeout_o)
`ifdef RV_CTRL_PERF_EN
     ,.cycle_cnt_o  (cycle_cnt_o),
      .instret_cnt_o(instret_cnt_o)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ALU codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
   function automatic int alu_of(input logic [2:0] f3);
      case (f3)
         3'd0: return 0;
         3'd1: return 5;
         3'd2: return 8;
         3'd3: return 9;
         3'd4: return 4;
         3'd5: return 6;
         3'd6: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic gen_legal(output logic [31:0] ins, output int alu, output bit bsel);
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  hi7;
      logic [11:0] imm12;
      f3  = 3'($urandom);
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      alu = alu_of(f3);
      if ($urandom_range(0, 1) == 0) begin
         hi7 = 7'h00;
         if (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) begin
            hi7 = 7'h20;
            alu = (f3 == 3'd0) ? 1 : 7;
         end
         ins  = {hi7, rs2, rs1, f3, rd, 7'h33};
         bsel = 1'b0;
      end else begin
         imm12 = 12'($urandom);
         if (f3 == 3'd1) begin
            imm12[11:5] = 7'h00;
         end else if (f3 == 3'd5) begin
            if ($urandom_range(0, 1) == 1) begin
               imm12[11:5] = 7'h20;
               alu = 7;
            end else begin
               imm12[11:5] = 7'h00;
            end
         end
         ins  = {imm12, rs1, f3, rd, 7'h13};
         bsel = 1'b1;
      end
   endtask

   task automatic gen_illegal(output logic [31:0] ins);
      logic [2:0] f3;
      logic [6:0] hi7, opc;
      logic [4:0] rd, rs1, rs2;
      f3  = 3'($urandom);
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      case ($urandom_range(0, 4))
         0: begin
            while ((f3 == 3'd0) || (f3 == 3'd5)) f3 = 3'($urandom);
            ins = {7'h20, rs2, rs1, f3, rd, 7'h33};
         end
         1: begin
            hi7 = 7'h00;
            while ((hi7 == 7'h00) || (hi7 == 7'h20)) hi7 = 7'($urandom);
            ins = {hi7, rs2, rs1, f3, rd, 7'h33};
         end
         2: begin
            hi7 = 7'h00;
            while (hi7 == 7'h00) hi7 = 7'($urandom);
            ins = {hi7, rs2, rs1, 3'd1, rd, 7'h13};
         end
         3: begin
            hi7 = 7'h00;
            while ((hi7 == 7'h00) || (hi7 == 7'h20)) hi7 = 7'($urandom);
            ins = {hi7, rs2, rs1, 3'd5, rd, 7'h13};
         end
         default: begin
            opc = 7'h33;
            while ((opc == 7'h33) || (opc == 7'h13)) opc = 7'($urandom);
            ins = {25'($urandom), opc};
         end
      endcase
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      start_i = 1'b0;
      halt_req_i = 1'b0;
      imem_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_imem_req", imem_req_o, 0);
      check_eq("rst_rf_wr_en", rf_wr_en_o, 0);
      check_eq("rst_pc_en", pc_en_o, 0);
      check_eq("rst_illegal", illegal_o, 0);
      check_eq("rst_timeout", timeout_o, 0);
      check_eq("rst_alu_sel", alu_sel_o, 0);
      check_eq("rst_op_b_sel", op_b_sel_o, 0);
      check_eq("rst_imm", imm_o, 0);
      check_eq("rst_wr_addr", wr_addr_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_eq("idle_holds", busy_o, 0);
   endtask

   task automatic start_cpu();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check_eq("start_busy", busy_o, 1);
   endtask

   task automatic check_fields(input string tag, input logic [31:0] ins, input int alu, input bit bsel);
      check_eq({tag, "_r_addr1"}, r_addr1_o, ins[19:15]);
      check_eq({tag, "_r_addr2"}, r_addr2_o, ins[24:20]);
      check_eq({tag, "_wr_addr"}, wr_addr_o, ins[11:7]);
      check_eq({tag, "_alu_sel"}, alu_sel_o, alu);
      check_eq({tag, "_op_b_sel"}, op_b_sel_o, bsel);
      if (bsel) check_eq({tag, "_imm"}, imm_o, {{20{ins[31]}}, ins[31:20]});
   endtask

   // Entered just after the negedge of a FETCH cycle.
   task automatic run_instr(input logic [31:0] ins, input int waits, input bit halt,
                            input bit legal, input int alu, input bit bsel);
      for (int k = 0; k < waits; k++) begin
         imem_ready_i = 1'b0;
         instr_i = $urandom;
         #1;
         check_eq("wait_imem_req", imem_req_o, 1);
         check_eq("wait_ir_load", ir_load_o, 0);
         @(negedge clk_i);
      end
      imem_ready_i = 1'b1;
      instr_i = ins;
      #1;
      check_eq("fetch_imem_req", imem_req_o, 1);
      check_eq("fetch_ir_load", ir_load_o, 1);
      @(negedge clk_i);
      imem_ready_i = 1'b0;
      instr_i = $urandom;
      check_eq("dec_busy", busy_o, 1);
      check_eq("dec_imem_req", imem_req_o, 0);
      check_eq("dec_pc_en", pc_en_o, 0);
      check_eq("dec_rf_wr_en", rf_wr_en_o, 0);
      @(negedge clk_i);
      if (!legal) begin
         check_eq("trap_illegal", illegal_o, 1);
         check_eq("trap_timeout", timeout_o, 0);
         check_eq("trap_busy", busy_o, 0);
         check_eq("trap_imem_req", imem_req_o, 0);
         check_eq("trap_pc_en", pc_en_o, 0);
         start_i = 1'b1;
         @(negedge clk_i);
         start_i = 1'b0;
         @(negedge clk_i);
         check_eq("trap_ignores_start", busy_o, 0);
         check_eq("trap_no_fetch", imem_req_o, 0);
         return;
      end
      check_fields("ex", ins, alu, bsel);
      check_eq("ex_rf_wr_en", rf_wr_en_o, 0);
      check_eq("ex_pc_en", pc_en_o, 0);
      halt_req_i = halt;
      @(negedge clk_i);
      check_fields("wb", ins, alu, bsel);
      check_eq("wb_rf_wr_en", rf_wr_en_o, (ins[11:7] != 5'd0));
      check_eq("wb_pc_en", pc_en_o, 1);
      @(negedge clk_i);
      halt_req_i = 1'b0;
      if (halt) check_eq("halt_idle", busy_o, 0);
      else      check_eq("next_fetch", imem_req_o, 1);
   endtask

   task automatic timeout_run();
      for (int k = 0; k < TO; k++) begin
         imem_ready_i = 1'b0;
         #1;
         check_eq("to_wait_req", imem_req_o, 1);
         @(negedge clk_i);
      end
      check_eq("to_timeout", timeout_o, 1);
      check_eq("to_imem_req", imem_req_o, 0);
      check_eq("to_busy", busy_o, 0);
      check_eq("to_illegal", illegal_o, 0);
   endtask

   initial begin
      logic [31:0] ins;
      int          alu;
      bit          bsel;
      int          n;

      apply_reset();
      start_cpu();
      run_instr(32'h003100B3, 0, 1'b0, 1'b1, 0, 1'b0);
      run_instr(32'hFFF00293, 0, 1'b0, 1'b1, 0, 1'b1);
      run_instr(32'h40315093, 1, 1'b0, 1'b1, 7, 1'b1);
      run_instr(32'h00000013, 0, 1'b1, 1'b1, 0, 1'b1);
      start_cpu();
      run_instr(32'h00000073, 0, 1'b0, 1'b0, 0, 1'b0);

      apply_reset();
      start_cpu();
      timeout_run();

      apply_reset();
      start_cpu();
      run_instr(32'h003100B3, TO - 1, 1'b1, 1'b1, 0, 1'b0);

      // Reset during EXECUTE must clear everything without a late write.
      start_cpu();
      imem_ready_i = 1'b1;
      instr_i = 32'h003100B3;
      @(negedge clk_i);
      imem_ready_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy_o, 0);
      check_eq("mid_rst_r_addr1", r_addr1_o, 0);
      check_eq("mid_rst_op_b_sel", op_b_sel_o, 0);
      @(posedge clk_i);
      #1;
      check_eq("mid_rst_rf_wr_en", rf_wr_en_o, 0);
      check_eq("mid_rst_pc_en", pc_en_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check_eq("mid_rst_idle", busy_o, 0);

      for (int t = 0; t < 9; t++) begin
         apply_reset();
         start_cpu();
         n = $urandom_range(3, 6);
         for (int i = 0; i < n; i++) begin
            gen_legal(ins, alu, bsel);
            run_instr(ins, $urandom_range(0, 3), (i == n - 1) && (t % 3 == 0), 1'b1, alu, bsel);
         end
         if (t % 3 == 1) begin
            gen_illegal(ins);
            run_instr(ins, $urandom_range(0, 3), 1'b0, 1'b0, 0, 1'b0);
         end else if (t % 3 == 2) begin
            timeout_run();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
